wave_play_out: RTL and testbench

// - Playback counterpart of the record path: pulls 16-bit samples from the SDRAM read port, buffers them,
//   and serializes them MSB-first onto the codec DAC data line, aligned to codec-driven dacclk (LRCLK) and bclk.
// - Sits between the SDRAM controller read side and the WM8731 DAC pins; dacclk/bclk are codec outputs, asynchronous to clock_50M.

---
 rtl/audio_pkg.sv | 13 +
 rtl/play_sample_fifo.sv | 64 ++++++
 rtl/wave_play_out.sv | 184 ++++++++++++++++++
 tb/tb_wave_play_out.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio record/playback paths.
package audio_pkg;

    localparam int unsigned AUDIO_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPrefetch = 2'd1,
        StPlay     = 2'd2,
        StStop     = 2'd3
    } play_state_e;

endpackage

// File: rtl/play_sample_fifo.sv
// Small synchronous sample FIFO with show-ahead head output.
// The head bypasses to wr_data while empty so a same-cycle push+pop hands
// the incoming word straight through.
module play_sample_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clock_50M,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    // A pop while full frees a slot this cycle; a push while empty feeds a same-cycle pop.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);
    assign head    = empty ? wr_data : mem_q[rd_ptr_q];

    // Storage array, written on push; contents need no reset.
    always_ff @(posedge clock_50M) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wave_play_out.sv
// Playback path: fetches samples from the SDRAM read port into a prefetch
// FIFO and shifts them MSB-first onto the codec DAC line, one word per
// LRCLK half-period, with bits changing after each bclk falling edge.
module wave_play_out
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = AUDIO_DATA_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clock_50M,
    input  logic              rst_n,
    input  logic              dacclk,
    input  logic              bclk,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic [DATA_W-1:0] wav_out_data,
    input  logic              wav_rd_valid,
    output logic              wav_rden,
    output logic              dacdat,
    output logic              play_busy,
    output logic              underrun
);

    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_W + 1);

    logic [SYNC_STAGES-1:0] lr_sync_q;
    logic [SYNC_STAGES-1:0] bclk_sync_q;
    logic                   lr_hist_q;
    logic                   bclk_hist_q;
    logic                   lr_edge;
    logic                   bclk_fall;

    play_state_e            state_q;
    logic                   wav_rden_q;
    logic                   outstanding_q;
    logic                   underrun_q;

    logic [DATA_W-1:0]      shreg_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic                   dacdat_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [DATA_W-1:0]      fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   rden_req;
    logic [DATA_W-1:0]      word;
    logic                   underrun_set;

    // Codec clocks into the clock_50M domain, plus one history flop for edges.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            lr_sync_q   <= '0;
            bclk_sync_q <= '0;
            lr_hist_q   <= 1'b0;
            bclk_hist_q <= 1'b0;
        end else begin
            lr_sync_q   <= (lr_sync_q << 1) | SYNC_STAGES'(dacclk);
            bclk_sync_q <= (bclk_sync_q << 1) | SYNC_STAGES'(bclk);
            lr_hist_q   <= lr_sync_q[SYNC_STAGES-1];
            bclk_hist_q <= bclk_sync_q[SYNC_STAGES-1];
        end
    end

    assign lr_edge   = lr_sync_q[SYNC_STAGES-1] != lr_hist_q;
    assign bclk_fall = bclk_hist_q & ~bclk_sync_q[SYNC_STAGES-1];

    // Returned data is only trusted when we actually asked for it.
    assign fifo_push = wav_rd_valid & outstanding_q;
    assign fifo_pop  = lr_edge & ((state_q == StPlay) | (state_q == StStop));
    // Don't launch a read in the cycle we are being told to stop.
    assign rden_req  = ((state_q == StPrefetch) | (state_q == StPlay)) & ~outstanding_q &
                       ~play_stop & (fifo_count < CNT_W'(FIFO_DEPTH));

    play_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock_50M (clock_50M),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .wr_data   (wav_out_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Word loaded at a boundary: FIFO head, or silence when nothing is available.
    always_comb begin
        word         = '0;
        underrun_set = 1'b0;
        if (fifo_pop) begin
            if (!fifo_empty || fifo_push) begin
                word = fifo_head;
            end else if (state_q == StPlay) begin
                underrun_set = 1'b1;
            end
        end
    end

    // Playback FSM with read-request handshake and sticky underrun flag.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wav_rden_q    <= 1'b0;
            outstanding_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            wav_rden_q <= rden_req;
            if (rden_req) begin
                outstanding_q <= 1'b1;
            end else if (fifo_push) begin
                outstanding_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (play_start) begin
                        state_q    <= StPrefetch;
                        underrun_q <= 1'b0;
                    end
                end
                StPrefetch: begin
                    if (play_stop) begin
                        state_q <= StStop;
                    end else if (fifo_full) begin
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    if (underrun_set) begin
                        underrun_q <= 1'b1;
                    end
                    if (play_stop) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (lr_edge && fifo_empty && !outstanding_q) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Serializer: load at word boundaries, shift one bit per bclk falling edge.
    always_ff @(posedge clock_50M or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= BIT_CNT_W'(DATA_W);
            dacdat_q  <= 1'b0;
        end else if (lr_edge) begin
            if (bclk_fall) begin
                dacdat_q  <= word[DATA_W-1];
                shreg_q   <= word << 1;
                bit_cnt_q <= BIT_CNT_W'(1);
            end else begin
                shreg_q   <= word;
                bit_cnt_q <= '0;
            end
        end else if (bclk_fall) begin
            if (bit_cnt_q < BIT_CNT_W'(DATA_W)) begin
                dacdat_q  <= shreg_q[DATA_W-1];
                shreg_q   <= shreg_q << 1;
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end else begin
                dacdat_q <= 1'b0;
            end
        end
    end

    assign wav_rden  = wav_rden_q;
    assign dacdat    = dacdat_q;
    assign play_busy = (state_q != StIdle);
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_wave_play_out.sv
`timescale 1ns/1ps
module tb_wave_play_out;
    import audio_pkg::*;

    logic        clock_50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        dacclk = 1'b0;
    logic        bclk = 1'b1;
    logic        play_start = 1'b0;
    logic        play_stop = 1'b0;
    logic [15:0] wav_out_data = 16'h0;
    logic        wav_rd_valid = 1'b0;
    logic        wav_rden;
    logic        dacdat;
    logic        play_busy;
    logic        underrun;

    wave_play_out dut (
        .clock_50M    (clock_50M),
        .rst_n        (rst_n),
        .dacclk       (dacclk),
        .bclk         (bclk),
        .play_start   (play_start),
        .play_stop    (play_stop),
        .wav_out_data (wav_out_data),
        .wav_rd_valid (wav_rd_valid),
        .wav_rden     (wav_rden),
        .dacdat       (dacdat),
        .play_busy    (play_busy),
        .underrun     (underrun)
    );

    always #10 clock_50M = ~clock_50M;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Codec model: bclk ~1.54 MHz, LRCLK toggles every 16 bclk periods on a
    // falling bclk edge. The receiver samples dacdat on each rising bclk and
    // records one 16-bit word per LRCLK half-period.
    event        lr_tog;
    logic [15:0] rx[$];
    initial begin
        logic [15:0] cur;
        cur = 16'h0;
        #3;
        forever begin
            for (int b = 0; b < 16; b++) begin
                bclk = 1'b0;
                if (b == 0) begin
                    dacclk = ~dacclk;
                    -> lr_tog;
                end
                #325;
                bclk = 1'b1;
                cur = {cur[14:0], dacdat};
                #325;
            end
            rx.push_back(cur);
        end
    end

    // SDRAM read model: answers 3 cycles after each rden, either from a
    // two-word table followed by zeros, or with random non-zero words.
    logic        pend = 1'b0;
    int          lat = 0;
    int          rden_cnt = 0;
    int          dbl_cnt = 0;
    logic [15:0] sent[$];
    int          sent_base = 0;
    int          answer_limit = 1 << 30;
    logic        tbl_mode = 1'b1;
    logic [15:0] tbl_w0 = 16'h0;
    logic [15:0] tbl_w1 = 16'h0;

    always @(negedge clock_50M) begin
        logic [15:0] w;
        int          idx;
        wav_rd_valid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (wav_rden) begin
            rden_cnt++;
            if (pend) dbl_cnt++;
            pend = 1'b1;
            lat  = 2;
        end else if (pend && (sent.size() - sent_base) < answer_limit) begin
            if (lat > 1) begin
                lat--;
            end else begin
                idx = sent.size() - sent_base;
                if (tbl_mode) w = (idx == 0) ? tbl_w0 : (idx == 1) ? tbl_w1 : 16'h0;
                else          w = 16'($urandom_range(1, 65535));
                wav_out_data = w;
                wav_rd_valid = 1'b1;
                sent.push_back(w);
                pend = 1'b0;
            end
        end
    end

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [47:0] exp_bits;
    } vec_t;

    int rx_base = 0;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock_50M);
        #1;
    endtask

    task automatic begin_scenario();
        sent_base = sent.size();
        rx_base   = rx.size();
    endtask

    task automatic start_play();
        @(lr_tog);
        wait_cycles(10);
        play_start = 1'b1;
        wait_cycles(1);
        play_start = 1'b0;
    endtask

    task automatic stop_in_flight(output int cnt_at_stop);
        int n = 0;
        while (!pend && n < 3000) begin
            wait_cycles(1);
            n++;
        end
        check("read_in_flight_at_stop", pend, 1'b1);
        play_stop   = 1'b1;
        cnt_at_stop = rden_cnt;
        wait_cycles(1);
        play_stop = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (play_busy && n < 8000) begin
            wait_cycles(1);
            n++;
        end
        check(name, play_busy, 1'b0);
    endtask

    // Everything the SDRAM returned must appear on dacdat, in order, once each.
    task automatic nz_compare(input string name);
        logic [15:0] nz[$];
        int          bad = -1;
        for (int i = rx_base; i < rx.size(); i++) if (rx[i] != 16'h0) nz.push_back(rx[i]);
        if (nz.size() == sent.size() - sent_base) begin
            for (int i = 0; i < nz.size(); i++)
                if (bad < 0 && nz[i] != sent[sent_base + i]) bad = i;
        end else begin
            bad = 0;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: played %0d words, required %0d, first bad index %0d",
                     name, nz.size(), sent.size() - sent_base, bad);
        end
    endtask

    initial begin
        vec_t vecs[3];
        int   cnt_stop;
        int   k;
        int   n;
        vecs[0] = '{16'hA5C3, 16'h0001, 48'hA5C3_0001_0000};
        vecs[1] = '{16'h8000, 16'hFFFE, 48'h8000_FFFE_0000};
        vecs[2] = '{16'h1234, 16'h0F0F, 48'h1234_0F0F_0000};

        // Reset with codec clocks running
        wait_cycles(50);
        check("rst_wav_rden", wav_rden, 1'b0);
        check("rst_dacdat", dacdat, 1'b0);
        check("rst_play_busy", play_busy, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_fifo_count", 64'(dut.u_fifo.count_q), 64'd0);
        rst_n = 1'b1;
        wait_cycles(30);
        check("idle_after_reset", 64'(dut.state_q), 64'(StIdle));
        check("no_rden_in_idle", rden_cnt, 0);
        check("idle_busy", play_busy, 1'b0);

        // Table-driven serialize scenarios: two words then zeros, stop/drain
        for (int v = 0; v < 3; v++) begin
            tbl_mode = 1'b1;
            tbl_w0   = vecs[v].w0;
            tbl_w1   = vecs[v].w1;
            begin_scenario();
            n = rden_cnt;
            start_play();
            wait_cycles(60);
            check("prefetch_rden_count", rden_cnt - n, 4);
            check("prefetch_to_play", 64'(dut.state_q), 64'(StPlay));
            check("play_busy", play_busy, 1'b1);
            repeat (4) @(lr_tog);
            stop_in_flight(cnt_stop);
            wait_idle("drain_to_idle");
            check("no_rden_after_stop", rden_cnt, cnt_stop);
            check("drain_no_underrun", underrun, 1'b0);
            check("drain_fifo_empty", 64'(dut.u_fifo.count_q), 64'd0);
            k = -1;
            for (int i = rx_base; i < rx.size(); i++) if (k < 0 && rx[i] != 16'h0) k = i;
            if (k >= 0 && k + 2 < rx.size()) check("serial_bits", {rx[k], rx[k+1], rx[k+2]}, vecs[v].exp_bits);
            else check("serial_word_found", 64'(k), 64'(rx.size()));
        end

        // Random words, stop with a read in flight, everything drains
        tbl_mode = 1'b0;
        begin_scenario();
        start_play();
        repeat (6) @(lr_tog);
        stop_in_flight(cnt_stop);
        wait_idle("rand_drain_to_idle");
        check("rand_no_rden_after_stop", rden_cnt, cnt_stop);
        check("rand_no_underrun", underrun, 1'b0);
        nz_compare("rand_stream");

        // Underrun: SDRAM goes silent after 6 words
        begin_scenario();
        answer_limit = 6;
        start_play();
        repeat (12) @(lr_tog);
        wait_cycles(20);
        check("underrun_set", underrun, 1'b1);
        check("underrun_busy", play_busy, 1'b1);
        check("underrun_zeros", {rx[rx.size()-1], rx[rx.size()-2]}, 32'h0);
        nz_compare("underrun_stream");
        answer_limit = 1 << 30;
        stop_in_flight(cnt_stop);
        wait_idle("underrun_stop_idle");
        check("underrun_sticky_idle", underrun, 1'b1);
        nz_compare("underrun_drain_stream");
        check("never_two_outstanding", dbl_cnt, 0);

        // play_start clears underrun; then async reset mid-word
        begin_scenario();
        start_play();
        wait_cycles(2);
        check("underrun_cleared", underrun, 1'b0);
        n = 0;
        while (dacdat !== 1'b1 && n < 3000) begin
            wait_cycles(1);
            n++;
        end
        check("dacdat_high_seen", dacdat, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_dacdat", dacdat, 1'b0);
        check("async_rst_busy", play_busy, 1'b0);
        check("async_rst_rden", wav_rden, 1'b0);
        check("async_rst_fifo", 64'(dut.u_fifo.count_q), 64'd0);
        wait_cycles(5);
        rst_n = 1'b1;
        n = rden_cnt;
        wait_cycles(40);
        check("post_rst_idle", 64'(dut.state_q), 64'(StIdle));
        check("post_rst_no_rden", rden_cnt, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
